spi_master_txn_seq: RTL and testbench

- Transaction sequencer between the SPI APB register interface and the bit-level TX/RX shift engines.
- A start strobe (rd/wr/qrd/qwr) latches the configuration, then runs CS setup, command, address, dummy and data phases in order.
- Each phase is a start/done handshake with the shift engines; chip select and status are driven for the whole transaction.
- End of transaction is signalled with an eot pulse.

---
 rtl/spi_master_txn_seq_if.sv | 41 ++++
 rtl/spi_master_txn_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_master_txn_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_txn_seq_if.sv
// rtl/spi_master_txn_seq_if.sv - start/done handshake bundle between the transaction sequencer and the TX/RX shift engines
//
// Signals:
//   tx_start/tx_len/tx_data/tx_from_fifo/tx_quad  sequencer -> TX engine phase request
//   tx_done                                       TX engine -> sequencer phase complete
//   rx_start/rx_len/rx_quad                       sequencer -> RX engine phase request
//   rx_done                                       RX engine -> sequencer phase complete
//   eng_abort                                     sequencer -> both engines abort pulse
// Modports: master = sequencer side, slave = engine side.

interface spi_master_txn_seq_if #(
    parameter int LEN_W = 16
);
    logic             tx_start;
    logic [LEN_W-1:0] tx_len;
    logic [31:0]      tx_data;
    logic             tx_from_fifo;
    logic             tx_quad;
    logic             tx_done;
    logic             rx_start;
    logic [LEN_W-1:0] rx_len;
    logic             rx_quad;
    logic             rx_done;
    logic             eng_abort;

    modport master (
        output tx_start, tx_len, tx_data, tx_from_fifo, tx_quad,
        input  tx_done,
        output rx_start, rx_len, rx_quad,
        input  rx_done,
        output eng_abort
    );

    modport slave (
        input  tx_start, tx_len, tx_data, tx_from_fifo, tx_quad,
        output tx_done,
        input  rx_start, rx_len, rx_quad,
        output rx_done,
        input  eng_abort
    );
endinterface

// File: rtl/spi_master_txn_seq.sv
// rtl/spi_master_txn_seq.sv - SPI transaction sequencer: CS setup, cmd, addr, dummy and data phases
//
// Ports:
//   HCLK, HRESETn                         clock, asynchronous active-low reset
//   spi_rd/spi_wr/spi_qrd/spi_qwr         one-cycle start strobes (std/quad read/write)
//   spi_swrst                             one-cycle soft reset / abort
//   spi_csreg                             one-hot chip-select selection
//   spi_cmd/spi_cmd_len                   right-aligned command and its bit length
//   spi_addr/spi_addr_len                 right-aligned address and its bit length
//   spi_data_len                          data phase length in bits
//   spi_dummy_rd/spi_dummy_wr             dummy SPI clocks for reads / writes
//   clk_tick                              one pulse per SPI bit period
//   eng                                   engine handshake (master modport)
//   spi_csn                               active-low chip selects
//   spi_status                            [6:0] one-hot state, [7] sticky start-while-busy
//   eot                                   one-cycle end-of-transaction pulse

module spi_master_txn_seq #(
    parameter int CS_NUM = 4,
    parameter int LEN_W  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  spi_rd,
    input  logic                  spi_wr,
    input  logic                  spi_qrd,
    input  logic                  spi_qwr,
    input  logic                  spi_swrst,
    input  logic [CS_NUM-1:0]     spi_csreg,
    input  logic [31:0]           spi_cmd,
    input  logic [5:0]            spi_cmd_len,
    input  logic [31:0]           spi_addr,
    input  logic [5:0]            spi_addr_len,
    input  logic [LEN_W-1:0]      spi_data_len,
    input  logic [LEN_W-1:0]      spi_dummy_rd,
    input  logic [LEN_W-1:0]      spi_dummy_wr,
    input  logic                  clk_tick,
    spi_master_txn_seq_if.master  eng,
    output logic [CS_NUM-1:0]     spi_csn,
    output logic [31:0]           spi_status,
    output logic                  eot
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CSS   = 3'd1,
        CMD   = 3'd2,
        ADDR  = 3'd3,
        DUMMY = 3'd4,
        DATA  = 3'd5,
        EOT   = 3'd6
    } state_t;

    state_t state, next_state;

    // Transaction configuration captured at the start strobe
    logic              dir_rd;
    logic              quad;
    logic [CS_NUM-1:0] cs_l;
    logic [31:0]       cmd_l;
    logic [5:0]        cmd_len_l;
    logic [31:0]       addr_l;
    logic [5:0]        addr_len_l;
    logic [LEN_W-1:0]  data_len_l;
    logic [LEN_W-1:0]  dummy_l;

    logic [LEN_W-1:0]  dummy_cnt, dummy_cnt_n;
    logic              err, err_n;

    logic              tx_start_q, tx_start_n;
    logic [LEN_W-1:0]  tx_len_q, tx_len_n;
    logic [31:0]       tx_data_q, tx_data_n;
    logic              tx_fifo_q, tx_fifo_n;
    logic              tx_quad_q, tx_quad_n;
    logic              rx_start_q, rx_start_n;
    logic [LEN_W-1:0]  rx_len_q, rx_len_n;
    logic              rx_quad_q, rx_quad_n;
    logic              abort_q, abort_n;
    logic              eot_q, eot_n;

    logic              any_start;
    logic              accept;
    logic              has_cmd, has_addr, has_dummy, has_data;
    state_t            after_css, after_cmd, after_addr, after_dummy;
    logic [6:0]        state_onehot;

    function automatic logic [5:0] clamp32(input logic [5:0] len);
        return (len > 6'd32) ? 6'd32 : len;
    endfunction

    assign any_start = spi_rd | spi_wr | spi_qrd | spi_qwr;

    assign has_cmd   = (cmd_len_l != 6'd0);
    assign has_addr  = (addr_len_l != 6'd0);
    assign has_dummy = (dummy_l != '0);
    assign has_data  = (data_len_l != '0);

    // Phase skipping: each phase hands over to the next one with a non-zero length
    assign after_dummy = has_data  ? DATA  : EOT;
    assign after_addr  = has_dummy ? DUMMY : after_dummy;
    assign after_cmd   = has_addr  ? ADDR  : after_addr;
    assign after_css   = has_cmd   ? CMD   : after_cmd;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            err        <= 1'b0;
            dummy_cnt  <= '0;
            tx_start_q <= 1'b0;
            tx_len_q   <= '0;
            tx_data_q  <= '0;
            tx_fifo_q  <= 1'b0;
            tx_quad_q  <= 1'b0;
            rx_start_q <= 1'b0;
            rx_len_q   <= '0;
            rx_quad_q  <= 1'b0;
            abort_q    <= 1'b0;
            eot_q      <= 1'b0;
        end else begin
            state      <= next_state;
            err        <= err_n;
            dummy_cnt  <= dummy_cnt_n;
            tx_start_q <= tx_start_n;
            tx_len_q   <= tx_len_n;
            tx_data_q  <= tx_data_n;
            tx_fifo_q  <= tx_fifo_n;
            tx_quad_q  <= tx_quad_n;
            rx_start_q <= rx_start_n;
            rx_len_q   <= rx_len_n;
            rx_quad_q  <= rx_quad_n;
            abort_q    <= abort_n;
            eot_q      <= eot_n;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_rd     <= 1'b0;
            quad       <= 1'b0;
            cs_l       <= '0;
            cmd_l      <= '0;
            cmd_len_l  <= '0;
            addr_l     <= '0;
            addr_len_l <= '0;
            data_len_l <= '0;
            dummy_l    <= '0;
        end else if (accept) begin
            // Read wins when read and write strobes coincide
            dir_rd     <= spi_rd | spi_qrd;
            quad       <= spi_qrd | spi_qwr;
            cs_l       <= spi_csreg;
            cmd_l      <= spi_cmd;
            cmd_len_l  <= clamp32(spi_cmd_len);
            addr_l     <= spi_addr;
            addr_len_l <= clamp32(spi_addr_len);
            data_len_l <= spi_data_len;
            dummy_l    <= (spi_rd | spi_qrd) ? spi_dummy_rd : spi_dummy_wr;
        end
    end

    always_comb begin
        next_state  = state;
        err_n       = err;
        dummy_cnt_n = dummy_cnt;
        accept      = 1'b0;
        tx_start_n  = 1'b0;
        rx_start_n  = 1'b0;
        abort_n     = 1'b0;
        eot_n       = 1'b0;
        tx_len_n    = tx_len_q;
        tx_data_n   = tx_data_q;
        tx_fifo_n   = tx_fifo_q;
        tx_quad_n   = tx_quad_q;
        rx_len_n    = rx_len_q;
        rx_quad_n   = rx_quad_q;

        if (spi_swrst) begin
            next_state = IDLE;
            err_n      = 1'b0;
            abort_n    = (state != IDLE);
        end else begin
            if (any_start && (state != IDLE)) begin
                err_n = 1'b1;
            end

            // A done in the same cycle as this phase's start pulse belongs to
            // nothing we issued, so it is only honoured once the pulse is gone.
            case (state)
                IDLE: begin
                    if (any_start) begin
                        accept     = 1'b1;
                        next_state = CSS;
                    end
                end
                CSS: next_state = after_css;
                CMD: begin
                    if (eng.tx_done && !tx_start_q) next_state = after_cmd;
                end
                ADDR: begin
                    if (eng.tx_done && !tx_start_q) next_state = after_addr;
                end
                DUMMY: begin
                    if (clk_tick) begin
                        if (dummy_cnt == LEN_W'(1)) begin
                            next_state = after_dummy;
                        end
                        dummy_cnt_n = dummy_cnt - LEN_W'(1);
                    end
                end
                DATA: begin
                    if (dir_rd) begin
                        if (eng.rx_done && !rx_start_q) next_state = EOT;
                    end else begin
                        if (eng.tx_done && !tx_start_q) next_state = EOT;
                    end
                end
                EOT: begin
                    eot_n      = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase

            // Entry actions: engine requests are registered so they appear in
            // the first cycle of the new state.
            if (next_state != state) begin
                case (next_state)
                    CMD: begin
                        tx_start_n = 1'b1;
                        tx_len_n   = LEN_W'(cmd_len_l);
                        tx_data_n  = cmd_l << (6'd32 - cmd_len_l);
                        tx_fifo_n  = 1'b0;
                        tx_quad_n  = 1'b0;
                    end
                    ADDR: begin
                        tx_start_n = 1'b1;
                        tx_len_n   = LEN_W'(addr_len_l);
                        tx_data_n  = addr_l << (6'd32 - addr_len_l);
                        tx_fifo_n  = 1'b0;
                        tx_quad_n  = quad;
                    end
                    DUMMY: dummy_cnt_n = dummy_l;
                    DATA: begin
                        if (dir_rd) begin
                            rx_start_n = 1'b1;
                            rx_len_n   = data_len_l;
                            rx_quad_n  = quad;
                        end else begin
                            tx_start_n = 1'b1;
                            tx_len_n   = data_len_l;
                            tx_fifo_n  = 1'b1;
                            tx_quad_n  = quad;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_onehot = 7'd1 << state;

    assign spi_csn    = ((state != IDLE) && (state != EOT)) ? ~cs_l : '1;
    assign spi_status = {24'd0, err, state_onehot};
    assign eot        = eot_q;

    assign eng.tx_start     = tx_start_q;
    assign eng.tx_len       = tx_len_q;
    assign eng.tx_data      = tx_data_q;
    assign eng.tx_from_fifo = tx_fifo_q;
    assign eng.tx_quad      = tx_quad_q;
    assign eng.rx_start     = rx_start_q;
    assign eng.rx_len       = rx_len_q;
    assign eng.rx_quad      = rx_quad_q;
    assign eng.eng_abort    = abort_q;

endmodule

// File: tb/tb_spi_master_txn_seq.sv
// tb/tb_spi_master_txn_seq.sv - directed self-checking bench for spi_master_txn_seq

module tb_spi_master_txn_seq;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        spi_rd = 1'b0, spi_wr = 1'b0, spi_qrd = 1'b0, spi_qwr = 1'b0;
    logic        spi_swrst = 1'b0;
    logic [3:0]  spi_csreg = '0;
    logic [31:0] spi_cmd = '0;
    logic [5:0]  spi_cmd_len = '0;
    logic [31:0] spi_addr = '0;
    logic [5:0]  spi_addr_len = '0;
    logic [15:0] spi_data_len = '0;
    logic [15:0] spi_dummy_rd = '0;
    logic [15:0] spi_dummy_wr = '0;
    logic        clk_tick = 1'b0;
    logic [3:0]  spi_csn;
    logic [31:0] spi_status;
    logic        eot;

    int errors = 0;
    int checks = 0;
    int ticks;
    int guard;
    logic seen;

    spi_master_txn_seq_if #(.LEN_W(16)) eng_if ();

    spi_master_txn_seq #(.CS_NUM(4), .LEN_W(16)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .spi_rd       (spi_rd),
        .spi_wr       (spi_wr),
        .spi_qrd      (spi_qrd),
        .spi_qwr      (spi_qwr),
        .spi_swrst    (spi_swrst),
        .spi_csreg    (spi_csreg),
        .spi_cmd      (spi_cmd),
        .spi_cmd_len  (spi_cmd_len),
        .spi_addr     (spi_addr),
        .spi_addr_len (spi_addr_len),
        .spi_data_len (spi_data_len),
        .spi_dummy_rd (spi_dummy_rd),
        .spi_dummy_wr (spi_dummy_wr),
        .clk_tick     (clk_tick),
        .eng          (eng_if.master),
        .spi_csn      (spi_csn),
        .spi_status   (spi_status),
        .eot          (eot)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic set_cfg(input logic [3:0] cs, input logic [31:0] cmd, input logic [5:0] cmd_len,
                           input logic [31:0] addr, input logic [5:0] addr_len, input logic [15:0] data_len,
                           input logic [15:0] drd, input logic [15:0] dwr);
        spi_csreg    = cs;
        spi_cmd      = cmd;
        spi_cmd_len  = cmd_len;
        spi_addr     = addr;
        spi_addr_len = addr_len;
        spi_data_len = data_len;
        spi_dummy_rd = drd;
        spi_dummy_wr = dwr;
    endtask

    initial begin
        eng_if.tx_done = 1'b0;
        eng_if.rx_done = 1'b0;

        // Reset state
        step();
        check_eq("rst_status", spi_status, 32'h1);
        check_eq("rst_csn", spi_csn, 4'hF);
        check_eq("rst_eot", eot, 1'b0);
        check_eq("rst_tx_start", eng_if.tx_start, 1'b0);
        check_eq("rst_tx_len", eng_if.tx_len, 16'd0);
        HRESETn = 1'b1;
        step();

        // Quad read: CMD -> ADDR -> DUMMY -> DATA
        set_cfg(4'b0010, 32'hEB, 6'd8, 32'h123456, 6'd24, 16'd64, 16'd6, 16'd0);
        spi_qrd = 1'b1;
        step();
        spi_qrd = 1'b0;
        check_eq("qrd_css", spi_status, 32'h2);
        check_eq("qrd_css_csn", spi_csn, 4'b1101);
        step();
        check_eq("qrd_cmd_state", spi_status, 32'h4);
        check_eq("qrd_cmd_start", eng_if.tx_start, 1'b1);
        check_eq("qrd_cmd_len", eng_if.tx_len, 16'd8);
        check_eq("qrd_cmd_data", eng_if.tx_data, 32'hEB000000);
        check_eq("qrd_cmd_quad", eng_if.tx_quad, 1'b0);
        check_eq("qrd_cmd_fifo", eng_if.tx_from_fifo, 1'b0);
        eng_if.tx_done = 1'b1;
        step();
        check_eq("done_with_start_ignored", spi_status, 32'h4);
        check_eq("qrd_cmd_start_one_cycle", eng_if.tx_start, 1'b0);
        step();
        eng_if.tx_done = 1'b0;
        check_eq("qrd_addr_state", spi_status, 32'h8);
        check_eq("qrd_addr_start", eng_if.tx_start, 1'b1);
        check_eq("qrd_addr_data", eng_if.tx_data, 32'h12345600);
        check_eq("qrd_addr_len", eng_if.tx_len, 16'd24);
        check_eq("qrd_addr_quad", eng_if.tx_quad, 1'b1);
        step();
        eng_if.rx_done = 1'b1;
        step();
        eng_if.rx_done = 1'b0;
        check_eq("addr_wrong_engine", spi_status, 32'h8);
        eng_if.tx_done = 1'b1;
        step();
        eng_if.tx_done = 1'b0;
        check_eq("qrd_dummy_state", spi_status, 32'h10);
        check_eq("qrd_dummy_csn", spi_csn, 4'b1101);
        ticks = 0;
        guard = 0;
        while (spi_status[4] && guard < 40) begin
            clk_tick = guard[0];
            if (clk_tick) ticks++;
            guard++;
            step();
            clk_tick = 1'b0;
        end
        check_eq("qrd_dummy_ticks", ticks, 6);
        check_eq("qrd_data_state", spi_status, 32'h20);
        check_eq("qrd_rx_start", eng_if.rx_start, 1'b1);
        check_eq("qrd_rx_len", eng_if.rx_len, 16'd64);
        check_eq("qrd_rx_quad", eng_if.rx_quad, 1'b1);
        check_eq("qrd_no_tx_start", eng_if.tx_start, 1'b0);
        check_eq("qrd_data_csn", spi_csn, 4'b1101);
        step();
        eng_if.rx_done = 1'b1;
        step();
        eng_if.rx_done = 1'b0;
        check_eq("qrd_eot_state", spi_status, 32'h40);
        check_eq("qrd_eot_csn", spi_csn, 4'hF);
        check_eq("qrd_eot_early", eot, 1'b0);
        step();
        check_eq("qrd_eot_pulse", eot, 1'b1);
        check_eq("qrd_idle", spi_status, 32'h1);
        step();
        check_eq("qrd_eot_one_cycle", eot, 1'b0);

        // Std write: ADDR and DUMMY skipped, busy strobe flagged
        set_cfg(4'b0001, 32'hA5, 6'd8, 32'h0, 6'd0, 16'd32, 16'd6, 16'd0);
        spi_wr = 1'b1;
        step();
        spi_wr = 1'b0;
        step();
        check_eq("wr_cmd_data", eng_if.tx_data, 32'hA5000000);
        step();
        eng_if.tx_done = 1'b1;
        step();
        eng_if.tx_done = 1'b0;
        check_eq("wr_skip_to_data", spi_status, 32'h20);
        check_eq("wr_tx_start", eng_if.tx_start, 1'b1);
        check_eq("wr_tx_fifo", eng_if.tx_from_fifo, 1'b1);
        check_eq("wr_tx_len", eng_if.tx_len, 16'd32);
        check_eq("wr_tx_quad", eng_if.tx_quad, 1'b0);
        check_eq("wr_no_rx_start", eng_if.rx_start, 1'b0);
        spi_wr = 1'b1;
        step();
        spi_wr = 1'b0;
        check_eq("busy_err_set", spi_status, 32'hA0);
        eng_if.tx_done = 1'b1;
        step();
        eng_if.tx_done = 1'b0;
        check_eq("wr_eot_state", spi_status, 32'hC0);
        step();
        check_eq("wr_eot_pulse", eot, 1'b1);
        check_eq("busy_err_sticky", spi_status, 32'h81);
        spi_swrst = 1'b1;
        step();
        spi_swrst = 1'b0;
        check_eq("swrst_clears_err", spi_status, 32'h1);
        check_eq("swrst_idle_no_abort", eng_if.eng_abort, 1'b0);

        // All lengths zero: IDLE -> CSS -> EOT -> IDLE
        set_cfg(4'b0001, 32'h0, 6'd0, 32'h0, 6'd0, 16'd0, 16'd0, 16'd0);
        spi_wr = 1'b1;
        step();
        spi_wr = 1'b0;
        seen = eng_if.tx_start | eng_if.rx_start;
        check_eq("zero_css_csn", spi_csn, 4'b1110);
        check_eq("zero_no_eot_1", eot, 1'b0);
        step();
        seen = seen | eng_if.tx_start | eng_if.rx_start;
        check_eq("zero_eot_csn", spi_csn, 4'hF);
        check_eq("zero_eot_state", spi_status, 32'h40);
        check_eq("zero_no_eot_2", eot, 1'b0);
        step();
        seen = seen | eng_if.tx_start | eng_if.rx_start;
        check_eq("zero_eot_3_cycles", eot, 1'b1);
        check_eq("zero_no_engine_start", seen, 1'b0);

        // Clamp cmd_len=40 and read/write strobe priority
        set_cfg(4'b0100, 32'h9ABCDEF0, 6'd40, 32'h0, 6'd0, 16'd16, 16'd0, 16'd3);
        spi_rd = 1'b1;
        spi_wr = 1'b1;
        step();
        spi_rd = 1'b0;
        spi_wr = 1'b0;
        step();
        check_eq("clamp_tx_len", eng_if.tx_len, 16'd32);
        check_eq("clamp_tx_data", eng_if.tx_data, 32'h9ABCDEF0);
        step();
        eng_if.tx_done = 1'b1;
        step();
        eng_if.tx_done = 1'b0;
        check_eq("rdwr_is_read", spi_status, 32'h20);
        check_eq("rdwr_rx_start", eng_if.rx_start, 1'b1);
        check_eq("rdwr_rx_len", eng_if.rx_len, 16'd16);
        check_eq("rdwr_rx_quad", eng_if.rx_quad, 1'b0);
        step();
        eng_if.rx_done = 1'b1;
        step();
        eng_if.rx_done = 1'b0;
        step();
        check_eq("rdwr_eot", eot, 1'b1);

        // Abort during DUMMY
        set_cfg(4'b0010, 32'h0, 6'd0, 32'h0, 6'd0, 16'd8, 16'd5, 16'd0);
        spi_qrd = 1'b1;
        step();
        spi_qrd = 1'b0;
        step();
        check_eq("abort_in_dummy", spi_status, 32'h10);
        spi_rd = 1'b1;
        step();
        spi_rd = 1'b0;
        check_eq("abort_err_before", spi_status, 32'h90);
        spi_swrst = 1'b1;
        step();
        spi_swrst = 1'b0;
        check_eq("abort_status", spi_status, 32'h1);
        check_eq("abort_pulse", eng_if.eng_abort, 1'b1);
        check_eq("abort_csn", spi_csn, 4'hF);
        check_eq("abort_no_eot", eot, 1'b0);
        eng_if.rx_done = 1'b1;
        step();
        eng_if.rx_done = 1'b0;
        check_eq("abort_pulse_one_cycle", eng_if.eng_abort, 1'b0);
        check_eq("abort_late_done_status", spi_status, 32'h1);
        check_eq("abort_late_done_no_eot", eot, 1'b0);
        check_eq("abort_late_done_no_rx", eng_if.rx_start, 1'b0);
        step();
        check_eq("abort_no_eot_later", eot, 1'b0);

        // Asynchronous reset mid-ADDR
        set_cfg(4'b1000, 32'h0, 6'd0, 32'hBEEF, 6'd16, 16'd0, 16'd0, 16'd0);
        spi_qwr = 1'b1;
        step();
        spi_qwr = 1'b0;
        step();
        check_eq("ar_addr_state", spi_status, 32'h8);
        check_eq("ar_addr_data", eng_if.tx_data, 32'hBEEF0000);
        check_eq("ar_addr_quad", eng_if.tx_quad, 1'b1);
        check_eq("ar_addr_csn", spi_csn, 4'b0111);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("ar_status", spi_status, 32'h1);
        check_eq("ar_csn", spi_csn, 4'hF);
        check_eq("ar_tx_len", eng_if.tx_len, 16'd0);
        check_eq("ar_tx_data", eng_if.tx_data, 32'h0);
        check_eq("ar_tx_quad", eng_if.tx_quad, 1'b0);
        check_eq("ar_tx_start", eng_if.tx_start, 1'b0);
        check_eq("ar_eot", eot, 1'b0);
        step();
        HRESETn = 1'b1;
        step();
        check_eq("ar_after_release", spi_status, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
